// File: rtl/posit_fault_monitor.sv
// Two-stage monitor that decodes a full-precision posit and its truncated twin, flags divergence and
// drives the TRUNC/FULL precision select. Define FAULT_MON_LOG_EN to add first-fault operand capture.
module posit_fault_monitor #(
  parameter int FULL_NBITS  = 32,
  parameter int TRUNC_NBITS = 16,
  parameter int ES          = 2,
  parameter int FRAC_SIZE   = 3,
  parameter int SCALE_W     = 8,
  parameter int SCALE_TOL   = 0,
  parameter int FAULT_LIMIT = 2,
  parameter int CLEAN_LIMIT = 4,
  parameter int CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [FULL_NBITS-1:0]     true_in,
  input  logic [FULL_NBITS-1:0]     used_in,
  input  logic                      clr_stats,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      fault,
  output logic signed [SCALE_W-1:0] true_scale,
  output logic signed [SCALE_W-1:0] used_scale,
  output logic                      mode,
  output logic [CNT_W-1:0]          fault_count
`ifdef FAULT_MON_LOG_EN
  ,
  output logic                      first_fault_valid,
  output logic [FULL_NBITS-1:0]     first_fault_true,
  output logic [FULL_NBITS-1:0]     first_fault_used
`endif
);

  localparam int RUN_MAX = (FAULT_LIMIT > CLEAN_LIMIT) ? FAULT_LIMIT : CLEAN_LIMIT;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  localparam logic [FULL_NBITS-1:0] USED_MASK =
    {FULL_NBITS{1'b1}} << (FULL_NBITS - TRUNC_NBITS);

  typedef enum logic [1:0] {CLS_ZERO, CLS_NAR, CLS_NORM} cls_e;
  typedef enum logic {MODE_TRUNC = 1'b0, MODE_FULL = 1'b1} mode_e;

  typedef struct packed {
    cls_e                      cls;
    logic                      sign;
    logic signed [SCALE_W-1:0] scale;
    logic [FRAC_SIZE-1:0]      frac;
  } dec_t;

  function automatic dec_t decode(input logic [FULL_NBITS-1:0] x);
    dec_t                  d;
    logic [FULL_NBITS-2:0] body;
    logic [FULL_NBITS-2:0] rem;
    logic [ES-1:0]         e;
    logic                  first;
    logic                  run;
    int                    r;
    int                    k;
    d = '0;
    if (x == '0) begin
      d.cls = CLS_ZERO;
    end else if (x == {1'b1, {(FULL_NBITS-1){1'b0}}}) begin
      d.cls = CLS_NAR;
    end else begin
      d.cls  = CLS_NORM;
      d.sign = x[FULL_NBITS-1];
      // Low bits of the two's complement equal the negation of the low bits alone.
      body   = x[FULL_NBITS-1] ? -x[FULL_NBITS-2:0] : x[FULL_NBITS-2:0];
      first  = body[FULL_NBITS-2];
      r      = 0;
      run    = 1'b1;
      for (int i = FULL_NBITS-2; i >= 0; i--) begin
        if (run && (body[i] == first)) r = r + 1;
        else                           run = 1'b0;
      end
      rem     = body << (r + 1);
      e       = ES'(rem >> (FULL_NBITS - 1 - ES));
      d.frac  = FRAC_SIZE'(rem >> (FULL_NBITS - 1 - ES - FRAC_SIZE));
      k       = first ? (r - 1) : -r;
      d.scale = SCALE_W'(k * (2 ** ES) + int'(e));
    end
    return d;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic                      w_adv;
  logic                      w_s2_en;
  logic [FULL_NBITS-1:0]     w_used_m;
  dec_t                      w_dec_true;
  dec_t                      w_dec_used;
  logic signed [SCALE_W:0]   w_dscale;
  logic [SCALE_W:0]          w_dabs;
  logic                      w_fault;
  mode_e                     w_state_nxt;
  logic [RUN_W-1:0]          w_frun_nxt;
  logic [RUN_W-1:0]          w_crun_nxt;
  logic [RUN_W-1:0]          w_frun_inc;
  logic [RUN_W-1:0]          w_crun_inc;
  logic [CNT_W-1:0]          w_cnt_nxt;

  logic                      r_vld_p1;
  dec_t                      r_dec_true_p1;
  dec_t                      r_dec_used_p1;
  logic                      r_vld_p2;
  logic                      r_fault_p2;
  logic signed [SCALE_W-1:0] r_true_scale_p2;
  logic signed [SCALE_W-1:0] r_used_scale_p2;
  mode_e                     r_state;
  logic [RUN_W-1:0]          r_frun;
  logic [RUN_W-1:0]          r_crun;
  logic [CNT_W-1:0]          r_fault_cnt;

  assign w_adv      = !r_vld_p2 || out_ready;
  assign w_s2_en    = w_adv && r_vld_p1;
  assign w_used_m   = used_in & USED_MASK;
  assign w_dec_true = decode(true_in);
  assign w_dec_used = decode(w_used_m);

  // Stage S1: register decoded operands
  always_ff @(posedge clk) begin
    if (!rst_n)     r_vld_p1 <= 1'b0;
    else if (w_adv) r_vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_dec_true_p1 <= w_dec_true;
      r_dec_used_p1 <= w_dec_used;
    end
  end

  assign w_dscale = $signed({r_dec_true_p1.scale[SCALE_W-1], r_dec_true_p1.scale})
                  - $signed({r_dec_used_p1.scale[SCALE_W-1], r_dec_used_p1.scale});
  assign w_dabs   = w_dscale[SCALE_W] ? -w_dscale : w_dscale;

  always_comb begin
    w_fault = 1'b0;
    if (r_dec_true_p1.cls != r_dec_used_p1.cls) begin
      w_fault = 1'b1;
    end else if (r_dec_true_p1.cls == CLS_NORM) begin
      w_fault = (r_dec_true_p1.sign != r_dec_used_p1.sign)
             || (w_dabs > (SCALE_W+1)'(SCALE_TOL))
             || ((w_dscale == '0) && (r_dec_true_p1.frac != r_dec_used_p1.frac));
    end
  end

  assign w_frun_inc = r_frun + RUN_W'(1);
  assign w_crun_inc = r_crun + RUN_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_frun_nxt  = r_frun;
    w_crun_nxt  = r_crun;
    w_cnt_nxt   = r_fault_cnt;
    if (w_s2_en) begin
      if (w_fault) w_cnt_nxt = sat_inc(r_fault_cnt);
      case (r_state)
        MODE_TRUNC: begin
          if (!w_fault) begin
            w_frun_nxt = '0;
          end else if (w_frun_inc >= RUN_W'(FAULT_LIMIT)) begin
            w_state_nxt = MODE_FULL;
            w_frun_nxt  = '0;
            w_crun_nxt  = '0;
          end else begin
            w_frun_nxt = w_frun_inc;
          end
        end
        MODE_FULL: begin
          if (w_fault) begin
            w_crun_nxt = '0;
          end else if (w_crun_inc >= RUN_W'(CLEAN_LIMIT)) begin
            w_state_nxt = MODE_TRUNC;
            w_frun_nxt  = '0;
            w_crun_nxt  = '0;
          end else begin
            w_crun_nxt = w_crun_inc;
          end
        end
        default: w_state_nxt = MODE_TRUNC;
      endcase
    end
    // A clear in the same cycle as a faulting sample leaves the count at zero.
    if (clr_stats) begin
      w_cnt_nxt  = '0;
      w_frun_nxt = '0;
      w_crun_nxt = '0;
    end
  end

  // Stage S2: compare results, mode FSM, counters and outputs
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= MODE_TRUNC;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frun      <= '0;
      r_crun      <= '0;
      r_fault_cnt <= '0;
    end else begin
      r_frun      <= w_frun_nxt;
      r_crun      <= w_crun_nxt;
      r_fault_cnt <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p2        <= 1'b0;
      r_fault_p2      <= 1'b0;
      r_true_scale_p2 <= '0;
      r_used_scale_p2 <= '0;
    end else if (w_adv) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_fault_p2      <= w_fault;
        r_true_scale_p2 <= r_dec_true_p1.scale;
        r_used_scale_p2 <= r_dec_used_p1.scale;
      end
    end
  end

  assign in_ready    = w_adv;
  assign out_valid   = r_vld_p2;
  assign fault       = r_fault_p2;
  assign true_scale  = r_true_scale_p2;
  assign used_scale  = r_used_scale_p2;
  assign mode        = r_state;
  assign fault_count = r_fault_cnt;

`ifdef FAULT_MON_LOG_EN
  logic [FULL_NBITS-1:0] r_true_p1;
  logic [FULL_NBITS-1:0] r_used_p1;
  logic                  r_ff_valid;
  logic [FULL_NBITS-1:0] r_ff_true;
  logic [FULL_NBITS-1:0] r_ff_used;
  logic                  w_ff_cap;

  assign w_ff_cap = w_s2_en && w_fault && !r_ff_valid && !clr_stats;

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_true_p1 <= true_in;
      r_used_p1 <= used_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_stats) r_ff_valid <= 1'b0;
    else if (w_ff_cap)       r_ff_valid <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_ff_cap) begin
      r_ff_true <= r_true_p1;
      r_ff_used <= r_used_p1;
    end
  end

  assign first_fault_valid = r_ff_valid;
  assign first_fault_true  = r_ff_true;
  assign first_fault_used  = r_ff_used;
`endif

endmodule
